fb_write_ctrl: RTL

FB_WRITE_CTRL -- requirements
Module: fb_write_ctrl

---
 rtl/fb_pkg.sv | 32 +++
 rtl/fb_write_ctrl_if.sv | 42 ++++
 rtl/fb_rr_arb2.sv | 30 +++
 rtl/fb_write_ctrl.sv | 129 ++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// fb_pkg: framebuffer geometry, port widths, write-controller FSM states and
// the constant-multiplier address helper shared by the framebuffer write
// controller, the framebuffer and the VGA scan-out path.
package fb_pkg;
  localparam int H_RES      = 640;
  localparam int V_RES      = 480;
  localparam int FB_PIXELS  = H_RES * V_RES;
  localparam int FB_ADDR_W  = 19;
  localparam int FB_COLOR_W = 24;
  localparam int FB_X_W     = 10;
  localparam int FB_Y_W     = 9;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } fb_state_e;

  // y*h_res + x as a shift-and-add over the set bits of the constant h_res.
  // With h_res fixed at elaboration this folds into a few adders
  // (640 -> (y<<9)+(y<<7)+x), so no multiplier is inferred.
  function automatic logic [FB_ADDR_W-1:0] fb_pix_addr(
    input logic [FB_X_W-1:0] x,
    input logic [FB_Y_W-1:0] y,
    input int                h_res
  );
    logic [FB_ADDR_W-1:0] acc;
    acc = {{(FB_ADDR_W-FB_X_W){1'b0}}, x};
    for (int i = 0; i < FB_X_W; i++)
      if (h_res[i]) acc = acc + ({{(FB_ADDR_W-FB_Y_W){1'b0}}, y} << i);
    return acc;
  endfunction
endpackage

// File: rtl/fb_write_ctrl_if.sv
// fb_write_ctrl_if: pixel requesters (r0 rasterizer, r1 host/blitter), clear
// control/status and the framebuffer write port of fb_write_ctrl.
//   master : requester / controller side (drives valid, pixel, clear_start)
//   slave  : fb_write_ctrl side (drives readies, status, write port)
interface fb_write_ctrl_if;
  import fb_pkg::*;

  logic                  r0_valid, r0_ready;
  logic [FB_X_W-1:0]     r0_x;
  logic [FB_Y_W-1:0]     r0_y;
  logic [FB_COLOR_W-1:0] r0_color;

  logic                  r1_valid, r1_ready;
  logic [FB_X_W-1:0]     r1_x;
  logic [FB_Y_W-1:0]     r1_y;
  logic [FB_COLOR_W-1:0] r1_color;

  logic                  clear_start;
  logic [FB_COLOR_W-1:0] clear_color;
  logic                  clear_busy, clear_done;

  logic [FB_ADDR_W-1:0]  fb_wr_addr;
  logic [FB_COLOR_W-1:0] fb_wr_data;
  logic                  fb_wr_enable;
  logic [15:0]           drop_count;

  modport master (
    output r0_valid, r0_x, r0_y, r0_color,
    output r1_valid, r1_x, r1_y, r1_color,
    output clear_start, clear_color,
    input  r0_ready, r1_ready, clear_busy, clear_done,
    input  fb_wr_addr, fb_wr_data, fb_wr_enable, drop_count
  );

  modport slave (
    input  r0_valid, r0_x, r0_y, r0_color,
    input  r1_valid, r1_x, r1_y, r1_color,
    input  clear_start, clear_color,
    output r0_ready, r1_ready, clear_busy, clear_done,
    output fb_wr_addr, fb_wr_data, fb_wr_enable, drop_count
  );
endinterface

// File: rtl/fb_rr_arb2.sv
// fb_rr_arb2: two-way round-robin arbiter.
//   clk, rst : clock, async active-high reset (priority returns to req[0])
//   en       : grants allowed this cycle
//   req[1:0] : requests;  gnt[1:0] : one-hot grant (zero when !en or no req)
// The requester not granted most recently wins a tie; the pointer only moves
// on a cycle that actually grants.
module fb_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  logic prio_q, prio_d;  // 1: req[1] wins a tie

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) gnt = prio_q ? 2'b10 : 2'b01;
      else              gnt = req;
    end
    prio_d = prio_q;
    if (gnt[0])      prio_d = 1'b1;
    else if (gnt[1]) prio_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) prio_q <= 1'b0;
    else     prio_q <= prio_d;
endmodule

// File: rtl/fb_write_ctrl.sv
// fb_write_ctrl: arbitrates two pixel requesters onto one framebuffer write
// port and performs full-frame clears.
//   clk, rst : clock, async active-high reset
//   bus      : fb_write_ctrl_if.slave -- r0/r1 pixel handshakes, clear
//              start/colour/busy/done, registered write port, drop counter
// Accepted in-range pixels are written one cycle later at y*H_RES+x;
// out-of-range pixels are accepted, discarded and counted (saturating).
// A clear sweeps addresses 0..H_RES*V_RES-1 with the colour latched at
// clear_start; the requesters are stalled for the whole sweep.
module fb_write_ctrl #(
  parameter int H_RES = fb_pkg::H_RES,
  parameter int V_RES = fb_pkg::V_RES
) (
  input logic            clk,
  input logic            rst,
  fb_write_ctrl_if.slave bus
);
  import fb_pkg::*;

  localparam int                   N_PIX = H_RES * V_RES;
  localparam logic [FB_ADDR_W-1:0] LAST  = FB_ADDR_W'(N_PIX - 1);
  localparam logic [FB_X_W:0]      X_LIM = (FB_X_W+1)'(H_RES);
  localparam logic [FB_Y_W:0]      Y_LIM = (FB_Y_W+1)'(V_RES);

  fb_state_e             state_q, state_d;
  logic                  wr_en_q, wr_en_d;
  logic [FB_ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [FB_COLOR_W-1:0] wr_data_q, wr_data_d;  // also holds the clear colour
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [15:0]           drop_q, drop_d;

  logic                  arb_en;
  logic [1:0]            gnt;
  logic [FB_X_W-1:0]     sel_x;
  logic [FB_Y_W-1:0]     sel_y;
  logic [FB_COLOR_W-1:0] sel_color;
  logic                  in_range;

  // No grant during reset, during a clear, or on the clear_start cycle.
  assign arb_en = (state_q == ST_IDLE) && !bus.clear_start && !rst;

  fb_rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .en  (arb_en),
    .req ({bus.r1_valid, bus.r0_valid}),
    .gnt (gnt)
  );

  assign bus.r0_ready = gnt[0];
  assign bus.r1_ready = gnt[1];

  assign sel_x     = gnt[1] ? bus.r1_x     : bus.r0_x;
  assign sel_y     = gnt[1] ? bus.r1_y     : bus.r0_y;
  assign sel_color = gnt[1] ? bus.r1_color : bus.r0_color;
  assign in_range  = ({1'b0, sel_x} < X_LIM) && ({1'b0, sel_y} < Y_LIM);

  // The write registers carry the clear sweep directly: entering CLEAR loads
  // address 0, so the first CLEAR cycle already presents a write and the last
  // CLEAR cycle presents LAST together with clear_done.
  always_comb begin
    state_d   = state_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    drop_d    = drop_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.clear_start) begin
          state_d   = ST_CLEAR;
          wr_en_d   = 1'b1;
          wr_addr_d = '0;
          wr_data_d = bus.clear_color;
          busy_d    = 1'b1;
          done_d    = (LAST == '0);
        end else if (|gnt) begin
          if (in_range) begin
            wr_en_d   = 1'b1;
            wr_addr_d = fb_pix_addr(sel_x, sel_y, H_RES);
            wr_data_d = sel_color;
          end else if (drop_q != 16'hFFFF) begin
            drop_d = drop_q + 16'd1;
          end
        end
      end
      ST_CLEAR: begin
        if (wr_addr_q == LAST) begin
          state_d = ST_IDLE;
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = wr_addr_q + 1'b1;
          busy_d    = 1'b1;
          done_d    = (wr_addr_q + 1'b1 == LAST);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      drop_q    <= drop_d;
    end
  end

  assign bus.fb_wr_enable = wr_en_q;
  assign bus.fb_wr_addr   = wr_addr_q;
  assign bus.fb_wr_data   = wr_data_q;
  assign bus.clear_busy   = busy_q;
  assign bus.clear_done   = done_q;
  assign bus.drop_count   = drop_q;
endmodule
